// File: rtl/enemy_missile_if.sv
// Launch handshake and wave-status bundle between the enemy missile launcher
// and its environment (spawn shift register, missile units, game controller).
interface enemy_missile_if #(
    parameter int SLOTS = 4
);
    logic             spawn_req;
    logic             frame_tick;
    logic             game_active;
    logic [SLOTS-1:0] slot_busy;
    logic             launch_ack;
    logic             launch_valid;
    logic [SLOTS-1:0] launch_slot;
    logic [9:0]       launch_x;
    logic [9:0]       launch_target_x;
    logic [5:0]       missiles_launched;
    logic             wave_done;

    modport master (
        input  spawn_req, frame_tick, game_active, slot_busy, launch_ack,
        output launch_valid, launch_slot, launch_x, launch_target_x,
               missiles_launched, wave_done
    );

    modport slave (
        output spawn_req, frame_tick, game_active, slot_busy, launch_ack,
        input  launch_valid, launch_slot, launch_x, launch_target_x,
               missiles_launched, wave_done
    );
endinterface

// File: rtl/enemy_missile_launcher.sv
// Wave sequencer: turns spawn requests into one-hot slot launches with
// LFSR-derived start/target positions, a frame-based cooldown and a per-wave count.
module enemy_missile_launcher #(
    parameter int SLOTS     = 4,
    parameter int COOLDOWN  = 30,
    parameter int WAVE_SIZE = 12
) (
    input  logic            clk,
    input  logic            rst,
    enemy_missile_if.master bus
);
    localparam int CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPAWN,
        S_LAUNCH,
        S_COOLDOWN,
        S_WAVE_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       lfsr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       count_q, count_d;
    logic [SLOTS-1:0] slot_q, slot_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       tx_q, tx_d;

    logic [SLOTS-1:0] free_onehot;
    logic             any_free;
    logic [5:0]       count_inc;

    // Screen is 640 wide; values 640..1023 fold back onto 256..639.
    function automatic logic [9:0] fold_x(input logic [9:0] v);
        return (v < 10'd640) ? v : (v - 10'd384);
    endfunction

    always_comb begin
        free_onehot = '0;
        any_free    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!any_free && !bus.slot_busy[i]) begin
                free_onehot[i] = 1'b1;
                any_free       = 1'b1;
            end
        end
    end

    assign count_inc = count_q + 6'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        slot_d  = slot_q;
        x_d     = x_q;
        tx_d    = tx_q;
        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (bus.game_active) state_d = S_WAIT_SPAWN;
            end
            S_WAIT_SPAWN: begin
                if (!bus.game_active) begin
                    state_d = S_IDLE;
                end else if (bus.spawn_req && bus.frame_tick && any_free) begin
                    state_d = S_LAUNCH;
                    slot_d  = free_onehot;
                    x_d     = fold_x(lfsr_q);
                    tx_d    = fold_x({lfsr_q[4:0], lfsr_q[9:5]});
                end
            end
            S_LAUNCH: begin
                // A dropped game_active still lets the pending handshake finish.
                if (bus.launch_ack) begin
                    if (count_q < 6'(WAVE_SIZE)) count_d = count_inc;
                    if (!bus.game_active) begin
                        state_d = S_IDLE;
                    end else if (count_inc >= 6'(WAVE_SIZE)) begin
                        state_d = S_WAVE_DONE;
                    end else begin
                        state_d = S_COOLDOWN;
                        cnt_d   = CNT_W'(COOLDOWN);
                    end
                end
            end
            S_COOLDOWN: begin
                if (!bus.game_active) begin
                    state_d = S_IDLE;
                end else if (bus.frame_tick) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_WAIT_SPAWN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            S_WAVE_DONE: begin
                if (!bus.game_active) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= 10'h2A5;
            cnt_q   <= '0;
            count_q <= '0;
            slot_q  <= '0;
            x_q     <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            cnt_q   <= cnt_d;
            count_q <= count_d;
            slot_q  <= slot_d;
            x_q     <= x_d;
            tx_q    <= tx_d;
        end
    end

    assign bus.launch_valid      = (state_q == S_LAUNCH);
    assign bus.wave_done         = (state_q == S_WAVE_DONE);
    assign bus.launch_slot       = slot_q;
    assign bus.launch_x          = x_q;
    assign bus.launch_target_x   = tx_q;
    assign bus.missiles_launched = count_q;
endmodule

// File: tb/tb_enemy_missile_launcher.sv
// Randomized bench for enemy_missile_launcher against a rule-level reference model.
module tb_enemy_missile_launcher;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    enemy_missile_if #(.SLOTS(4)) bus ();

    enemy_missile_launcher #(.SLOTS(4), .COOLDOWN(30), .WAVE_SIZE(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR value the DUT will sample at the next rising edge.
    logic [9:0] m_lfsr = 10'h2A5;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 10'h2A5;
        else     m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    int         m_count = 0;
    logic [9:0] exp_l;
    logic [3:0] exp_busy;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int fold(input int v);
        return (v < 640) ? v : v - 384;
    endfunction

    function automatic int rot5(input int v);
        return ((v % 32) * 32) + (v / 32);
    endfunction

    function automatic int lowest_free(input logic [3:0] busy);
        for (int i = 0; i < 4; i++) if (!busy[i]) return (1 << i);
        return 0;
    endfunction

    // Called on a falling edge: presents one spawn with frame_tick for one clk.
    task automatic spawn_try(input logic [3:0] busy);
        bus.slot_busy  = busy;
        bus.spawn_req  = 1'b1;
        bus.frame_tick = 1'b1;
        exp_busy       = busy;
        exp_l          = m_lfsr;
        @(negedge clk);
        bus.spawn_req  = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic check_launch(input string tag);
        check({tag, "_valid"}, int'(bus.launch_valid), 1);
        check({tag, "_slot"}, int'(bus.launch_slot), lowest_free(exp_busy));
        check({tag, "_x"}, int'(bus.launch_x), fold(int'(exp_l)));
        check({tag, "_tx"}, int'(bus.launch_target_x), fold(rot5(int'(exp_l))));
    endtask

    task automatic do_ack(input string tag);
        bus.launch_ack = 1'b1;
        @(negedge clk);
        bus.launch_ack = 1'b0;
        if (m_count < 12) m_count++;
        check({tag, "_ackvalid"}, int'(bus.launch_valid), 0);
        check({tag, "_count"}, int'(bus.missiles_launched), m_count);
    endtask

    // 30 frame ticks to leave cooldown; spawns during it must be ignored.
    task automatic cool_down(input bit noisy);
        for (int i = 0; i < 30; i++) begin
            bus.frame_tick = 1'b1;
            bus.spawn_req  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.slot_busy  = 4'($urandom_range(0, 7));
            @(negedge clk);
            bus.frame_tick = 1'b0;
            bus.spawn_req  = 1'b0;
            check("cooldown_quiet", int'(bus.launch_valid), 0);
            repeat ($urandom_range(0, 2)) begin
                bus.spawn_req = noisy;
                @(negedge clk);
                bus.spawn_req = 1'b0;
                check("untimed_spawn", int'(bus.launch_valid), 0);
            end
        end
    endtask

    initial begin
        int         n;
        int         guard;
        logic [3:0] busy;
        int         targets[3] = '{1023, 639, 640};
        int         folded[3]  = '{639, 639, 256};

        bus.spawn_req   = 1'b0;
        bus.frame_tick  = 1'b0;
        bus.game_active = 1'b0;
        bus.slot_busy   = 4'b0000;
        bus.launch_ack  = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", int'(bus.launch_valid), 0);
        check("rst_slot", int'(bus.launch_slot), 0);
        check("rst_x", int'(bus.launch_x), 0);
        check("rst_tx", int'(bus.launch_target_x), 0);
        check("rst_count", int'(bus.missiles_launched), 0);
        check("rst_done", int'(bus.wave_done), 0);

        rst = 1'b0;
        bus.game_active = 1'b1;
        @(negedge clk);
        spawn_try(4'b0000);
        check_launch("first");
        check("first_xrange", int'(bus.launch_x < 10'd640), 1);
        repeat (5) begin
            @(negedge clk);
            check_launch("hold");
        end
        do_ack("first");

        // Count ticks offered with spawn_req until one is accepted.
        n = 0;
        while (n < 40 && !bus.launch_valid) begin
            n++;
            spawn_try(4'b0000);
        end
        check("cooldown_ticks", n - 1, 30);
        check_launch("after_cd");
        do_ack("second");
        cool_down(1'b0);

        spawn_try(4'b0011);
        check_launch("busy0011");
        do_ack("third");
        cool_down(1'b1);

        spawn_try(4'b1111);
        check("all_busy", int'(bus.launch_valid), 0);
        bus.spawn_req = 1'b1;
        @(negedge clk);
        bus.spawn_req = 1'b0;
        check("no_tick", int'(bus.launch_valid), 0);

        guard = 0;
        while (m_count < 12 && guard < 200) begin
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                bus.launch_ack = 1'b1;
                @(negedge clk);
                bus.launch_ack = 1'b0;
                check("stray_ack", int'(bus.missiles_launched), m_count);
            end
            busy = ($urandom_range(0, 4) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
            spawn_try(busy);
            if (lowest_free(busy) == 0) begin
                check("rand_blocked", int'(bus.launch_valid), 0);
            end else begin
                check_launch("rand");
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    check_launch("rand_hold");
                end
                do_ack("rand");
                if (m_count < 12) cool_down(1'b1);
            end
        end
        check("wave_count", int'(bus.missiles_launched), 12);
        check("wave_done", int'(bus.wave_done), 1);
        spawn_try(4'b0000);
        check("done_no_launch", int'(bus.launch_valid), 0);
        check("done_count", int'(bus.missiles_launched), 12);
        bus.game_active = 1'b0;
        @(negedge clk);
        m_count = 0;
        check("idle_done", int'(bus.wave_done), 0);
        check("idle_count", int'(bus.missiles_launched), 0);

        // Losing game_active mid-handshake still completes the launch.
        bus.game_active = 1'b1;
        @(negedge clk);
        spawn_try(4'b0001);
        check_launch("gadrop");
        bus.game_active = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_launch("gadrop_hold");
        end
        do_ack("gadrop");
        @(negedge clk);
        m_count = 0;
        check("gadrop_idle_count", int'(bus.missiles_launched), 0);

        for (int t = 0; t < 3; t++) begin
            bus.game_active = 1'b1;
            @(negedge clk);
            n = 0;
            while (n < 2100 && int'(m_lfsr) != targets[t]) begin
                n++;
                @(negedge clk);
            end
            check("lfsr_reach", int'(m_lfsr), targets[t]);
            spawn_try(4'b0000);
            check("fold_x", int'(bus.launch_x), folded[t]);
            check("fold_tx", int'(bus.launch_target_x), fold(rot5(targets[t])));
            bus.game_active = 1'b0;
            do_ack("fold");
            @(negedge clk);
            m_count = 0;
        end

        bus.game_active = 1'b1;
        @(negedge clk);
        spawn_try(4'b1000);
        check_launch("prerst");
        #2 rst = 1'b1;
        #1;
        check("async_valid", int'(bus.launch_valid), 0);
        check("async_slot", int'(bus.launch_slot), 0);
        check("async_count", int'(bus.missiles_launched), 0);
        @(negedge clk);
        rst = 1'b0;
        m_count = 0;
        @(negedge clk);
        check("post_rst_count", int'(bus.missiles_launched), 0);
        check("post_rst_valid", int'(bus.launch_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout got=%0d exp=%0d", checks, 0);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/enemy_missile_launcher.md
ENEMY_MISSILE_LAUNCHER -- requirements
Module: enemy_missile_launcher

Interface
REQ-001 Parameter SLOTS, 4, number of enemy missile slots.
REQ-002 Parameter COOLDOWN, 30, frame_ticks between launches.
REQ-003 Parameter WAVE_SIZE, 12, missiles launched per wave.
REQ-004 Port clk  in  1  system clock; all state on posedge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port spawn_req  in  1  spawn bit from the enemy missile shift register.
REQ-007 Port frame_tick  in  1  one-clk pulse per video frame.
REQ-008 Port game_active  in  1  high while a wave is being played.
REQ-009 Port slot_busy  in  SLOTS  per-slot busy flags from the missile units.
REQ-010 Port launch_ack  in  1  missile unit accepted the launch.
REQ-011 Port launch_valid  out  1  launch request pending.
REQ-012 Port launch_slot  out  SLOTS  one-hot target slot, stable while launch_valid.
REQ-013 Port launch_x  out  10  start x, 0..639, stable while launch_valid.
REQ-014 Port launch_target_x  out  10  ground target x, 0..639, stable while launch_valid.
REQ-015 Port missiles_launched  out  6  count of acked launches this wave.
REQ-016 Port wave_done  out  1  high once WAVE_SIZE launches are acked.

Function
REQ-017 FSM states: IDLE, WAIT_SPAWN, LAUNCH, COOLDOWN, WAVE_DONE.
REQ-018 IDLE: missiles_launched held 0; game_active=1 -> WAIT_SPAWN next clk.
REQ-019 WAIT_SPAWN: spawn_req=1 and frame_tick=1 and any slot_busy bit 0 -> LAUNCH; else stay.
REQ-020 spawn_req with frame_tick=0, or with all slots busy, is dropped (no queueing).
REQ-021 On WAIT_SPAWN->LAUNCH, latch launch_slot = lowest-index free slot (one-hot), launch_x and launch_target_x from the LFSR.
REQ-022 LFSR: 10-bit Fibonacci, x^10+x^7+1, free-running every clk, seed 10'h2A5, never all-zero.
REQ-023 launch_x = L if L<640 else L-384, where L = LFSR value.
REQ-024 launch_target_x = same fold applied to R = {L[4:0],L[9:5]}.
REQ-025 LAUNCH: launch_valid=1 from first clk in state; slot/x/target_x unchanged until ack.
REQ-026 LAUNCH with launch_ack=1: launch_valid falls next clk; missiles_launched increments by 1.
REQ-027 After ack, new count == WAVE_SIZE -> WAVE_DONE; else -> COOLDOWN with counter loaded to COOLDOWN.
REQ-028 Ack latency: launch_ack in the same clk launch_valid first rises is valid (zero-wait).
REQ-029 COOLDOWN: counter decrements on each frame_tick; spawn_req ignored; on reaching 0 -> WAIT_SPAWN.
REQ-030 WAVE_DONE: wave_done=1; no launches; game_active=0 -> IDLE (wave_done falls, count clears).
REQ-031 game_active=0 in WAIT_SPAWN or COOLDOWN -> IDLE next clk.
REQ-032 game_active=0 during LAUNCH: handshake completes (hold until ack, count increments), then IDLE.
REQ-033 launch_ack outside LAUNCH is ignored.
REQ-034 missiles_launched never exceeds WAVE_SIZE; no wrap.

Reset
REQ-035 rst=1 asynchronously forces: state IDLE, launch_valid 0, launch_slot 0, launch_x 0, launch_target_x 0, missiles_launched 0, wave_done 0, cooldown counter 0, LFSR 10'h2A5.
REQ-036 rst mid-LAUNCH drops the pending request; no count increment.
REQ-037 Outputs leave reset values only on the first posedge after rst falls.

Verification
REQ-038 rst released, game_active=1, slot_busy=4'b0000, spawn_req=1 with frame_tick -> launch_valid=1, launch_slot=4'b0001, launch_x<640.
REQ-039 slot_busy=4'b0011 at spawn -> launch_slot=4'b0100; slot_busy=4'b1111 -> no launch_valid.
REQ-040 launch_valid held 5 clks without ack -> slot/x/target_x constant; ack -> launch_valid=0 next clk, missiles_launched=1, then exactly 30 frame_ticks before next launch accepted.
REQ-041 12 acked launches -> wave_done=1, count=12, further spawn_req ignored; game_active=0 -> IDLE, count=0.
REQ-042 rst asserted while launch_valid=1 -> launch_valid=0 immediately (no clk), count unchanged at 0 after release.
REQ-043 LFSR fold check: force L=1023 -> launch_x=639; L=639 -> launch_x=639; L=640 -> launch_x=256.
